// File: rtl/invaders_pkg.sv
// Shared geometry, timing constants and launcher state encoding for the alien bomb launcher.
package invaders_pkg;

    localparam int NB_LIN        = 4;
    localparam int NB_COL        = 8;
    localparam int ALIENS_WIDTH  = 20;
    localparam int STEP_H        = 20;
    localparam int ALIENS_HEIGHT = 10;
    localparam int STEP_V        = 10;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int LIMIT_BOTTOM  = 40;
    localparam int SHIP_WIDTH    = 30;
    localparam int SHIP_HEIGHT   = 10;

    localparam int NB_BOMBS      = 3;
    localparam int BOMB_SPEED    = 2;
    localparam int FIRE_PERIOD   = 45;
    localparam int LIVES_INIT    = 3;
    localparam int HIT_COOLDOWN  = 60;

    localparam int COL_PITCH     = ALIENS_WIDTH + STEP_H;
    localparam int ROW_PITCH     = ALIENS_HEIGHT + STEP_V;
    localparam int BOMB_Y_LIMIT  = SCREEN_HEIGHT - LIMIT_BOTTOM;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        SPAWN  = 2'd2
    } launcher_state_t;

    // Unsigned distance: pick the larger operand first so no signed math is needed.
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/alien_bomb_launcher_bomb_slot.sv
// One bomb slot: holds position, falls once per live frame, leaves play at the bottom,
// and flags a hit against the ship box. Hit or kill always wins over load and motion.
module bomb_slot
    import invaders_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [9:0] load_x,
    input  logic [9:0] load_y,
    input  logic       move,
    input  logic       kill,
    input  logic [9:0] x_ship,
    input  logic [9:0] y_ship,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hit
);

    logic        active_q, active_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] y_step;

    always_comb begin
        hit = active_q
              && (abs_diff(x_q, x_ship) < 10'(SHIP_WIDTH / 2))
              && (abs_diff(y_q, y_ship) < 10'(SHIP_HEIGHT / 2));
        y_step   = {1'b0, y_q} + 11'(BOMB_SPEED);
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        if (kill || hit) begin
            active_d = 1'b0;
        end else if (load) begin
            active_d = 1'b1;
            x_d      = load_x;
            y_d      = load_y;
        end else if (move && active_q) begin
            if (y_step >= 11'(BOMB_Y_LIMIT)) begin
                active_d = 1'b0;
            end else begin
                y_d = y_step[9:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active = active_q;
    assign x      = x_q;
    assign y      = y_q;

endmodule

// File: rtl/alien_bomb_launcher.sv
// Alien return fire: periodic column search for a bottom-most live alien, bomb spawn into
// the lowest free slot, and lives / cooldown / game-over bookkeeping from slot hits.
module alien_bomb_launcher
    import invaders_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frameTick,
    input  logic                     pause,
    input  logic [31:0]              alive,
    input  logic [9:0]               xAlien,
    input  logic [9:0]               yAlien,
    input  logic [9:0]               xShip,
    input  logic [9:0]               yShip,
    output logic [NB_BOMBS-1:0]      bombActive,
    output logic [10*NB_BOMBS-1:0]   xBombs,
    output logic [10*NB_BOMBS-1:0]   yBombs,
    output logic                     playerHit,
    output logic [1:0]               lives,
    output logic                     gameOver,
    output launcher_state_t          dbg_state
);

    launcher_state_t state_q, state_d;
    logic [5:0]  timer_q, timer_d, timer_next;
    logic [2:0]  col_q, col_d;
    logic [3:0]  scanned_q, scanned_d, scanned_inc;
    logic [1:0]  row_q, row_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [5:0]  cooldown_q, cooldown_d;
    logic [1:0]  lives_q, lives_d;
    logic        game_over_q, game_over_d;
    logic        player_hit_q, player_hit_d;

    logic [NB_BOMBS-1:0] slot_active, slot_hit, slot_load, free_onehot;
    logic        tick_live, move, kill_all, free_any, col_found, spawn_ok;
    logic [1:0]  col_row;
    logic [10:0] spawn_x, spawn_y;

    always_comb begin
        col_found = 1'b0;
        col_row   = '0;
        for (int i = 0; i < NB_LIN; i++) begin
            if (alive[i*NB_COL + int'(col_q)]) begin
                col_found = 1'b1;
                col_row   = 2'(i);
            end
        end
        // Downward scan so the lowest free index is the one left standing.
        free_onehot = '0;
        for (int k = NB_BOMBS - 1; k >= 0; k--) begin
            if (!slot_active[k]) begin
                free_onehot    = '0;
                free_onehot[k] = 1'b1;
            end
        end
        free_any = ~&slot_active;
        spawn_x  = {1'b0, xAlien} + 11'(col_q) * 11'(COL_PITCH);
        spawn_y  = {1'b0, yAlien} + 11'(row_q) * 11'(ROW_PITCH) + 11'(ALIENS_HEIGHT / 2);
        spawn_ok = (spawn_x < 11'(SCREEN_WIDTH)) && (spawn_y < 11'(BOMB_Y_LIMIT));
    end

    always_comb begin
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tick_live    = frameTick & ~pause;
        move         = tick_live & ~game_over_q;
        timer_next   = (timer_q == 6'd0) ? 6'd0 : timer_q - 6'd1;
        scanned_inc  = scanned_q + 4'd1;
        state_d      = state_q;
        timer_d      = timer_q;
        col_d        = col_q;
        scanned_d    = scanned_q;
        row_d        = row_q;
        cooldown_d   = cooldown_q;
        lives_d      = lives_q;
        game_over_d  = game_over_q;
        player_hit_d = 1'b0;
        kill_all     = 1'b0;
        slot_load    = '0;

        if (tick_live && cooldown_q != 6'd0) begin
            cooldown_d = cooldown_q - 6'd1;
        end
        // Simultaneous hits cost a single life; hits during cooldown only clear bombs.
        if (|slot_hit && cooldown_q == 6'd0) begin
            player_hit_d = 1'b1;
            lives_d      = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            cooldown_d   = 6'(HIT_COOLDOWN);
            if (lives_d == 2'd0) begin
                game_over_d = 1'b1;
                kill_all    = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (tick_live && !game_over_q) begin
                    if (timer_next == 6'd0 && free_any) begin
                        timer_d   = 6'(FIRE_PERIOD);
                        col_d     = lfsr_q[2:0];
                        scanned_d = '0;
                        state_d   = SEARCH;
                    end else begin
                        timer_d = timer_next;
                    end
                end
            end
            SEARCH: begin
                if (col_found) begin
                    row_d   = col_row;
                    state_d = SPAWN;
                end else begin
                    col_d     = col_q + 3'd1;
                    scanned_d = scanned_inc;
                    if (scanned_inc == 4'(NB_COL)) state_d = IDLE;
                end
            end
            SPAWN: begin
                if (spawn_ok) slot_load = free_onehot;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (game_over_d) begin
            state_d   = IDLE;
            slot_load = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= 6'(FIRE_PERIOD);
            col_q        <= '0;
            scanned_q    <= '0;
            row_q        <= '0;
            lfsr_q       <= 8'hA5;
            cooldown_q   <= '0;
            lives_q      <= 2'(LIVES_INIT);
            game_over_q  <= 1'b0;
            player_hit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            col_q        <= col_d;
            scanned_q    <= scanned_d;
            row_q        <= row_d;
            lfsr_q       <= lfsr_d;
            cooldown_q   <= cooldown_d;
            lives_q      <= lives_d;
            game_over_q  <= game_over_d;
            player_hit_q <= player_hit_d;
        end
    end

    for (genvar k = 0; k < NB_BOMBS; k++) begin : g_slot
        bomb_slot u_slot (
            .clk    (clk),
            .reset  (reset),
            .load   (slot_load[k]),
            .load_x (spawn_x[9:0]),
            .load_y (spawn_y[9:0]),
            .move   (move),
            .kill   (kill_all),
            .x_ship (xShip),
            .y_ship (yShip),
            .active (slot_active[k]),
            .x      (xBombs[10*k +: 10]),
            .y      (yBombs[10*k +: 10]),
            .hit    (slot_hit[k])
        );
    end

    assign bombActive = slot_active;
    assign playerHit  = player_hit_q;
    assign lives      = lives_q;
    assign gameOver   = game_over_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alien_bomb_launcher.sv
// Frame-level bench for alien_bomb_launcher: directed game scenarios plus randomized
// episodes, all checked against a per-frame behavioural model of the game rules.
module tb_alien_bomb_launcher;
    import invaders_pkg::*;

    localparam int FRAME_CYC = 14;

    logic clk = 1'b0, reset = 1'b0, frameTick = 1'b0, pause = 1'b0;
    logic [31:0] alive = '0;
    logic [9:0]  xAlien = '0, yAlien = '0, xShip = '0, yShip = '0;
    logic [2:0]  bombActive;
    logic [29:0] xBombs, yBombs;
    logic        playerHit, gameOver;
    logic [1:0]  lives;
    launcher_state_t dbg_state;

    int n_vec = 0, n_bad = 0;
    int last_pulses, last_search, exp_pulses;

    // Reference model state (frame granularity)
    logic [7:0] m_lfsr;
    bit         m_act[3];
    int         m_x[3], m_y[3];
    int         m_lives, m_cd, m_timer;
    bit         m_go;

    always #5 clk = ~clk;

    alien_bomb_launcher dut (
        .clk(clk), .reset(reset), .frameTick(frameTick), .pause(pause), .alive(alive),
        .xAlien(xAlien), .yAlien(yAlien), .xShip(xShip), .yShip(yShip),
        .bombActive(bombActive), .xBombs(xBombs), .yBombs(yBombs), .playerHit(playerHit),
        .lives(lives), .gameOver(gameOver), .dbg_state(dbg_state)
    );

    // x^8+x^6+x^5+x^4+1 sequence, one step per clock out of reset
    always @(posedge clk) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_act[k] = 0;
        m_lives = LIVES_INIT;
        m_cd    = 0;
        m_timer = FIRE_PERIOD;
        m_go    = 0;
    endtask

    task automatic model_hits();
        bit any = 0;
        for (int k = 0; k < 3; k++) begin
            if (m_act[k] && absd(m_x[k], int'(xShip)) < SHIP_WIDTH / 2
                         && absd(m_y[k], int'(yShip)) < SHIP_HEIGHT / 2) begin
                m_act[k] = 0;
                any = 1;
            end
        end
        if (any && m_cd == 0) begin
            exp_pulses++;
            if (m_lives > 0) m_lives--;
            m_cd = HIT_COOLDOWN;
            if (m_lives == 0) begin
                m_go = 1;
                for (int k = 0; k < 3; k++) m_act[k] = 0;
            end
        end
    endtask

    task automatic model_frame(input bit p, input logic [7:0] lf);
        bit launch = 0;
        bit free;
        int nt, start, col = 0, row = -1, sx, sy, slot = -1;
        exp_pulses = 0;
        if (p || m_go) return;
        if (m_cd > 0) m_cd--;
        free = !(m_act[0] && m_act[1] && m_act[2]);
        nt = (m_timer == 0) ? 0 : m_timer - 1;
        if (nt == 0 && free) begin
            m_timer = FIRE_PERIOD;
            launch = 1;
        end else begin
            m_timer = nt;
        end
        for (int k = 0; k < 3; k++) begin
            if (m_act[k]) begin
                m_y[k] += BOMB_SPEED;
                if (m_y[k] >= SCREEN_HEIGHT - LIMIT_BOTTOM) m_act[k] = 0;
            end
        end
        model_hits();
        if (!launch || m_go) return;
        start = int'(lf[2:0]);
        for (int c = 0; c < 8 && row < 0; c++) begin
            col = (start + c) % 8;
            for (int r = 0; r < 4; r++) if (alive[r*8 + col]) row = r;
        end
        if (row < 0) return;
        sx = int'(xAlien) + col * 40;
        sy = int'(yAlien) + row * 20 + 5;
        if (sx >= 640 || sy >= 440) return;
        for (int k = 2; k >= 0; k--) if (!m_act[k]) slot = k;
        if (slot < 0) return;
        m_act[slot] = 1;
        m_x[slot] = sx;
        m_y[slot] = sy;
        model_hits();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        frameTick = 1'b0;
        pause = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Drive one frame, let the launcher settle, then compare against the model.
    task automatic do_frame(input bit p);
        logic [7:0] lf;
        logic [2:0] exp_act;
        int pulses = 0, searches = 0;
        lf = m_lfsr;
        pause = p;
        frameTick = 1'b1;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            frameTick = 1'b0;
            if (playerHit === 1'b1) pulses++;
            if (dbg_state === SEARCH) searches++;
        end
        pause = 1'b0;
        last_pulses = pulses;
        last_search = searches;
        model_frame(p, lf);
        exp_act = {m_act[2], m_act[1], m_act[0]};
        n_vec++;
        if (bombActive !== exp_act) begin
            n_bad++;
            $display("FAIL frame_active: got %b expected %b", bombActive, exp_act);
        end
        for (int k = 0; k < 3; k++) begin
            if (m_act[k]) begin
                n_vec++;
                if (xBombs[10*k +: 10] !== 10'(m_x[k]) || yBombs[10*k +: 10] !== 10'(m_y[k])) begin
                    n_bad++;
                    $display("FAIL frame_pos slot%0d: got (%0d,%0d) expected (%0d,%0d)", k,
                             xBombs[10*k +: 10], yBombs[10*k +: 10], m_x[k], m_y[k]);
                end
            end
        end
        n_vec++;
        if (lives !== 2'(m_lives) || gameOver !== m_go) begin
            n_bad++;
            $display("FAIL frame_lives: got lives=%0d go=%b expected lives=%0d go=%b",
                     lives, gameOver, m_lives, m_go);
        end
        n_vec++;
        if (pulses != exp_pulses) begin
            n_bad++;
            $display("FAIL frame_pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_vec++;
        if (bombActive !== 3'b000 || xBombs !== 30'd0 || yBombs !== 30'd0) begin
            n_bad++;
            $display("FAIL %s_bombs: got act=%b x=%h y=%h expected all 0", tag, bombActive, xBombs, yBombs);
        end
        n_vec++;
        if (playerHit !== 1'b0 || gameOver !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_flags: got hit=%b go=%b expected 0 0", tag, playerHit, gameOver);
        end
        n_vec++;
        if (lives !== 2'd3) begin
            n_bad++;
            $display("FAIL %s_lives: got %0d expected 3", tag, lives);
        end
        n_vec++;
        if (dbg_state !== IDLE) begin
            n_bad++;
            $display("FAIL %s_state: got %0d expected %0d", tag, dbg_state, IDLE);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_values("reset");
    endtask

    task automatic test_spawn_and_exit();
        int total = 0;
        alive = 32'h1 << 10; xAlien = 10'd30; yAlien = 10'd30; xShip = 10'd500; yShip = 10'd440;
        apply_reset();
        repeat (45) do_frame(1'b0);
        n_vec++;
        if (bombActive[0] !== 1'b1 || xBombs[9:0] !== 10'd110 || yBombs[9:0] !== 10'd55) begin
            n_bad++;
            $display("FAIL spawn_pos: got act=%b (%0d,%0d) expected 1 (110,55)", bombActive[0], xBombs[9:0], yBombs[9:0]);
        end
        repeat (192) begin
            do_frame(1'b0);
            total += last_pulses;
        end
        n_vec++;
        if (bombActive[0] !== 1'b1 || yBombs[9:0] !== 10'd439) begin
            n_bad++;
            $display("FAIL exit_before: got act=%b y=%0d expected 1 439", bombActive[0], yBombs[9:0]);
        end
        do_frame(1'b0);
        total += last_pulses;
        n_vec++;
        if (bombActive[0] !== 1'b0 || total != 0) begin
            n_bad++;
            $display("FAIL exit_bottom: got act=%b hits=%0d expected 0 0", bombActive[0], total);
        end
    endtask

    task automatic test_ship_hit();
        int total = 0;
        alive = 32'h1 << 10; xAlien = 10'd30; yAlien = 10'd30; xShip = 10'd110; yShip = 10'd440;
        apply_reset();
        repeat (45) do_frame(1'b0);
        repeat (190) begin
            do_frame(1'b0);
            total += last_pulses;
        end
        n_vec++;
        if (total != 0 || bombActive[0] !== 1'b1 || yBombs[9:0] !== 10'd435) begin
            n_bad++;
            $display("FAIL hit_before: got hits=%0d act=%b y=%0d expected 0 1 435", total, bombActive[0], yBombs[9:0]);
        end
        do_frame(1'b0);
        n_vec++;
        if (last_pulses != 1 || lives !== 2'd2 || bombActive[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_at_437: got hits=%0d lives=%0d act=%b expected 1 2 0", last_pulses, lives, bombActive[0]);
        end
    endtask

    task automatic test_empty_formation();
        alive = '0; xAlien = 10'd30; yAlien = 10'd30; xShip = 10'd500; yShip = 10'd440;
        apply_reset();
        repeat (44) do_frame(1'b0);
        n_vec++;
        if (last_search != 0) begin
            n_bad++;
            $display("FAIL early_search: got %0d cycles expected 0", last_search);
        end
        do_frame(1'b0);
        n_vec++;
        if (last_search != 8 || dbg_state !== IDLE || bombActive !== 3'b000) begin
            n_bad++;
            $display("FAIL empty_search: got cycles=%0d state=%0d act=%b expected 8 %0d 000",
                     last_search, dbg_state, bombActive, IDLE);
        end
    endtask

    task automatic test_game_over();
        logic [1:0] exp_q[$];
        logic [1:0] seen_q[$];
        bit first = 1;
        exp_q = '{2'd2, 2'd1, 2'd0};
        alive = 32'h1 << 10; xAlien = 10'd30; yAlien = 10'd30; xShip = 10'd110; yShip = 10'd440;
        apply_reset();
        repeat (45) do_frame(1'b0);
        // The next bomb spawns at the same height as the first, so both reach the ship together.
        yAlien = 10'd120;
        for (int f = 0; f < 800 && gameOver !== 1'b1; f++) begin
            do_frame(1'b0);
            if (last_pulses > 0) begin
                seen_q.push_back(lives);
                if (first) begin
                    first = 0;
                    n_vec++;
                    if (bombActive[1:0] !== 2'b00 || last_pulses != 1 || lives !== 2'd2) begin
                        n_bad++;
                        $display("FAIL double_hit: got act=%b hits=%0d lives=%0d expected x00 1 2",
                                 bombActive, last_pulses, lives);
                    end
                end
            end
        end
        n_vec++;
        if (gameOver !== 1'b1 || bombActive !== 3'b000) begin
            n_bad++;
            $display("FAIL game_over: got go=%b act=%b expected 1 000", gameOver, bombActive);
        end
        n_vec++;
        if (seen_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL lives_seq_len: got %0d expected %0d", seen_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_vec++;
                if (seen_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL lives_seq[%0d]: got %0d expected %0d", i, seen_q[i], exp_q[i]);
                end
            end
        end
        repeat (60) do_frame(1'b0);
        n_vec++;
        if (bombActive !== 3'b000 || lives !== 2'd0 || gameOver !== 1'b1) begin
            n_bad++;
            $display("FAIL after_over: got act=%b lives=%0d go=%b expected 000 0 1", bombActive, lives, gameOver);
        end
    endtask

    task automatic test_reset_mid_search();
        alive = 32'h1 << 10; xAlien = 10'd30; yAlien = 10'd30; xShip = 10'd500; yShip = 10'd440;
        apply_reset();
        repeat (134) do_frame(1'b0);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        n_vec++;
        if (dbg_state !== SEARCH || bombActive !== 3'b011) begin
            n_bad++;
            $display("FAIL pre_reset: got state=%0d act=%b expected %0d 011", dbg_state, bombActive, SEARCH);
        end
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("mid_reset");
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int xs;
        for (int ep = 0; ep < 5; ep++) begin
            alive  = (ep == 4) ? 32'h0 : ($urandom & $urandom);
            xAlien = 10'($urandom_range(0, 680));
            yAlien = 10'($urandom_range(100, 420));
            xs = int'(xAlien) + 40 * $urandom_range(0, 7) + $urandom_range(0, 24) - 12;
            if (xs < 0) xs = 0;
            if (xs > 1023) xs = 1023;
            xShip = 10'(xs);
            yShip = 10'($urandom_range(200, 470));
            apply_reset();
            repeat (200) do_frame($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_and_exit();
        test_ship_hit();
        test_empty_formation();
        test_game_over();
        test_reset_mid_search();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
